ray_plane_t: RTL and testbench

//  Upstream neighbour of the hit-point stage. Per ray/triangle pair it computes the plane

---
 rtl/ray_plane_t_if.sv | 40 ++++
 rtl/ray_plane_t.sv | 200 ++++++++++++++++++++
 tb/tb_ray_plane_t.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ray_plane_t_if.sv
`default_nettype none
// ============================================================================
// Module      : ray_plane_t_if
// Description : Bundles the pair-input and FIFO-output signals of the
//               ray/plane parameter stage.
//               master : producer/consumer side (drives pairs, pops FIFO)
//               slave  : the ray_plane_t block
//               Ports:
//                 tri_normal/v0/origin/dir : signed Q vectors [x,y,z]
//                 in_wr_en / in_full       : pair push and back-pressure
//                 out_t/out_origin/out_dir : FIFO head, first-word fall-through
//                 out_miss                 : head flag, no forward hit
//                 out_rd_en / out_empty    : FIFO pop and empty status
// Revision    : 1.0 - initial release
// ============================================================================
interface ray_plane_t_if;
    logic [2:0][31:0] tri_normal;
    logic [2:0][31:0] v0;
    logic [2:0][31:0] origin;
    logic [2:0][31:0] dir;
    logic             in_wr_en;
    logic             in_full;
    logic [31:0]      out_t;
    logic [2:0][31:0] out_origin;
    logic [2:0][31:0] out_dir;
    logic             out_miss;
    logic             out_rd_en;
    logic             out_empty;

    modport master (
        output tri_normal, v0, origin, dir, in_wr_en, out_rd_en,
        input  in_full, out_t, out_origin, out_dir, out_miss, out_empty
    );

    modport slave (
        input  tri_normal, v0, origin, dir, in_wr_en, out_rd_en,
        output in_full, out_t, out_origin, out_dir, out_miss, out_empty
    );
endinterface
`default_nettype wire

// File: rtl/ray_plane_t.sv
`default_nettype none
// ============================================================================
// Module      : ray_plane_t
// Description : Computes t = dot(n, v0 - origin) / dot(n, dir) in signed
//               Q fixed point for one ray/triangle pair at a time, using a
//               31-cycle restoring divider, and queues {t, origin, dir, miss}
//               in an output FIFO (first-word fall-through).
//               Ports:
//                 clock : rising-edge clock
//                 reset : synchronous active-high; aborts pair, empties FIFO
//                 bus   : ray_plane_t_if.slave (pair input, FIFO output)
// Revision    : 1.0 - initial release
// ============================================================================
module ray_plane_t #(
    parameter int Q_BITS     = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic    clock,
    input  wire logic    reset,
    ray_plane_t_if.slave bus
);
    localparam int c_PW = $clog2(FIFO_DEPTH);
    localparam int c_CW = c_PW + 1;
    // Wide enough for |num|<<Q_BITS and for divisor<<31 without loss.
    localparam int c_DW = 68 + Q_BITS + 32;
    localparam logic [c_CW-1:0] c_DEPTH = c_CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DOT  = 2'd1,
        S_DIV  = 2'd2,
        S_PUSH = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [2:0][31:0] n_q, n_d, v0_q, v0_d, org_q, org_d, dir_q, dir_d;
    logic [c_DW-1:0]  rem_q, rem_d, dsh_q, dsh_d;
    logic [30:0]      quo_q, quo_d;
    logic [4:0]       cnt_q, cnt_d;
    logic             neg_q, neg_d, sat_q, sat_d, den0_q, den0_d;
    logic [c_PW-1:0]  wp_q, wp_d, rp_q, rp_d;
    logic [c_CW-1:0]  count_q, count_d;

    logic [31:0]      mem_t_q [FIFO_DEPTH];
    logic [2:0][31:0] mem_o_q [FIFO_DEPTH];
    logic [2:0][31:0] mem_d_q [FIFO_DEPTH];
    logic             mem_m_q [FIFO_DEPTH];

    logic signed [67:0] w_num, w_den;
    logic [67:0]        w_num_abs, w_den_abs;
    logic [c_DW-1:0]    w_dividend, w_divisor, w_diff;
    logic               w_sat, w_ge, w_full, w_accept, w_push, w_pop, w_miss;
    logic [30:0]        w_qmag;
    logic [31:0]        w_t;

    // Exact dot products: every term fits in 68 signed bits at Q(2*Q_BITS).
    always_comb begin
        w_num = '0;
        w_den = '0;
        for (int i = 0; i < 3; i++) begin
            w_num = w_num + (68'($signed(v0_q[i])) - 68'($signed(org_q[i])))
                            * 68'($signed(n_q[i]));
            w_den = w_den + 68'($signed(dir_q[i])) * 68'($signed(n_q[i]));
        end
    end

    assign w_num_abs  = w_num[67] ? 68'(-w_num) : 68'(w_num);
    assign w_den_abs  = w_den[67] ? 68'(-w_den) : 68'(w_den);
    assign w_dividend = c_DW'(w_num_abs) << Q_BITS;
    assign w_divisor  = c_DW'(w_den_abs);
    // Quotient would need more than 31 bits.
    assign w_sat      = w_dividend >= (w_divisor << 31);
    assign w_ge       = rem_q >= dsh_q;
    assign w_diff     = rem_q - dsh_q;

    assign w_qmag = sat_q ? 31'h7FFF_FFFF : quo_q;
    assign w_t    = den0_q ? 32'd0
                  : (neg_q ? 32'(-{1'b0, w_qmag}) : {1'b0, w_qmag});
    assign w_miss = den0_q | (neg_q & (|w_qmag));

    assign w_full   = (count_q == c_DEPTH);
    assign w_accept = bus.in_wr_en & (state_q == S_IDLE) & ~w_full;
    assign w_push   = (state_q == S_PUSH);
    assign w_pop    = bus.out_rd_en & (count_q != '0);

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        v0_d    = v0_q;
        org_d   = org_q;
        dir_d   = dir_q;
        rem_d   = rem_q;
        dsh_d   = dsh_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        sat_d   = sat_q;
        den0_d  = den0_q;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    n_d     = bus.tri_normal;
                    v0_d    = bus.v0;
                    org_d   = bus.origin;
                    dir_d   = bus.dir;
                    state_d = S_DOT;
                end
            end
            S_DOT: begin
                neg_d   = w_num[67] ^ w_den[67];
                sat_d   = w_sat;
                den0_d  = (w_den == '0);
                rem_d   = w_dividend;
                // Divisor starts aligned with quotient bit 30 and walks down.
                dsh_d   = w_divisor << 30;
                quo_d   = '0;
                cnt_d   = '0;
                state_d = (w_den == '0) ? S_PUSH : S_DIV;
            end
            S_DIV: begin
                if (w_ge) begin
                    rem_d = w_diff;
                end
                quo_d = {quo_q[29:0], w_ge};
                dsh_d = dsh_q >> 1;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd30) begin
                    state_d = S_PUSH;
                end
            end
            S_PUSH:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        wp_d = w_push ? wp_q + c_PW'(1) : wp_q;
        rp_d = w_pop  ? rp_q + c_PW'(1) : rp_q;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + c_CW'(1);
            2'b01:   count_d = count_q - c_CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            v0_q    <= '0;
            org_q   <= '0;
            dir_q   <= '0;
            rem_q   <= '0;
            dsh_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            sat_q   <= 1'b0;
            den0_q  <= 1'b0;
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            // Cleared so the fall-through head reads zero after reset.
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_t_q[i] <= '0;
                mem_o_q[i] <= '0;
                mem_d_q[i] <= '0;
                mem_m_q[i] <= 1'b0;
            end
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            v0_q    <= v0_d;
            org_q   <= org_d;
            dir_q   <= dir_d;
            rem_q   <= rem_d;
            dsh_q   <= dsh_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            sat_q   <= sat_d;
            den0_q  <= den0_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
            if (w_push) begin
                mem_t_q[wp_q] <= w_t;
                mem_o_q[wp_q] <= org_q;
                mem_d_q[wp_q] <= dir_q;
                mem_m_q[wp_q] <= w_miss;
            end
        end
    end

    assign bus.in_full    = (state_q != S_IDLE) | w_full;
    assign bus.out_empty  = (count_q == '0);
    assign bus.out_t      = mem_t_q[rp_q];
    assign bus.out_origin = mem_o_q[rp_q];
    assign bus.out_dir    = mem_d_q[rp_q];
    assign bus.out_miss   = mem_m_q[rp_q];
endmodule
`default_nettype wire

// File: tb/tb_ray_plane_t.sv
`default_nettype none
// ============================================================================
// Module      : tb_ray_plane_t
// Description : Self-checking bench for ray_plane_t. Directed pairs plus
//               random pairs compared against an arithmetic model of t.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ray_plane_t;
    localparam int Q = 10;

    typedef logic [2:0][31:0] vec_t;
    typedef struct {
        logic [31:0] t;
        logic        miss;
        vec_t        o;
        vec_t        d;
        bit          den0;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t expq[$];

    ray_plane_t_if bus ();

    ray_plane_t #(.Q_BITS(Q), .FIFO_DEPTH(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    function automatic vec_t mk(input int x, input int y, input int z);
        return {32'(z), 32'(y), 32'(x)};
    endfunction

    function automatic int r16();
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    function automatic exp_t model(input vec_t n, input vec_t v0, input vec_t o, input vec_t d);
        exp_t   e;
        longint num, den, a, b, q;
        bit     neg;
        num = 0;
        den = 0;
        for (int i = 0; i < 3; i++) begin
            num += longint'($signed(n[i])) * (longint'($signed(v0[i])) - longint'($signed(o[i])));
            den += longint'($signed(n[i])) * longint'($signed(d[i]));
        end
        e.o = o;
        e.d = d;
        e.den0 = (den == 0);
        if (den == 0) begin
            e.t = 0;
            e.miss = 1'b1;
        end else begin
            a = (num < 0 ? -num : num) << Q;
            b = (den < 0) ? -den : den;
            q = a / b;
            if (q > 64'sd2147483647) q = 2147483647;
            neg = (num < 0) != (den < 0);
            e.t = neg ? 32'(-q) : 32'(q);
            e.miss = neg && (q != 0);
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Compare the FIFO head with the oldest expected entry and retire it.
    task automatic check_head(input string tag);
        exp_t e;
        check({tag, "_valid"}, 96'(bus.out_empty), 96'(0));
        if (expq.size() > 0) begin
            e = expq.pop_front();
            check({tag, "_t"},      96'(bus.out_t),    96'(e.t));
            check({tag, "_miss"},   96'(bus.out_miss), 96'(e.miss));
            check({tag, "_origin"}, bus.out_origin,    e.o);
            check({tag, "_dir"},    bus.out_dir,       e.d);
        end
    endtask

    task automatic pop_check(input string tag);
        check_head(tag);
        bus.out_rd_en = 1'b1;
        @(posedge clock); #1;
        bus.out_rd_en = 1'b0;
    endtask

    // Pushes one pair. Returns the cycle offset from accept (A) at which
    // out_empty was first low and at which in_full dropped (-1 = never).
    task automatic run_pair(input vec_t n, input vec_t v0, input vec_t o, input vec_t d,
                            input int pop_at, input int rst_at,
                            output int lat_e, output int lat_f, output logic full1);
        exp_t e;
        e = model(n, v0, o, d);
        check("ready", 96'(bus.in_full), 96'(0));
        bus.tri_normal = n;
        bus.v0 = v0;
        bus.origin = o;
        bus.dir = d;
        bus.in_wr_en = 1'b1;
        @(posedge clock); #1;
        bus.in_wr_en = 1'b0;
        expq.push_back(e);
        full1 = bus.in_full;
        lat_e = -1;
        lat_f = -1;
        for (int k = 1; k <= 60; k++) begin
            if (lat_e < 0 && !bus.out_empty) lat_e = k;
            if (!bus.in_full) begin
                lat_f = k;
                break;
            end
            if (k == rst_at) begin
                reset = 1'b1;
                @(posedge clock); #1;
                reset = 1'b0;
                break;
            end
            if (k == pop_at) begin
                check_head("simul_head");
                bus.out_rd_en = 1'b1;
            end
            @(posedge clock); #1;
            bus.out_rd_en = 1'b0;
        end
    endtask

    initial begin
        int   le, lf;
        logic f1;
        exp_t e;
        vec_t nz, n, v, o, d;

        bus.tri_normal = '0;
        bus.v0 = '0;
        bus.origin = '0;
        bus.dir = '0;
        bus.in_wr_en = 1'b0;
        bus.out_rd_en = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;

        check("rst_empty", 96'(bus.out_empty), 96'(1));
        check("rst_full",  96'(bus.in_full),   96'(0));
        check("rst_t",     96'(bus.out_t),     96'(0));
        check("rst_miss",  96'(bus.out_miss),  96'(0));
        check("rst_org",   bus.out_origin,     96'(0));
        check("rst_dir",   bus.out_dir,        96'(0));

        nz = mk(0, 0, 1024);

        // Test 1: t = 5.0
        run_pair(nz, mk(0, 0, 5120), mk(0, 0, 0), mk(0, 0, 1024), 0, 0, le, lf, f1);
        check("t1_busy", 96'(f1), 96'(1));
        check("t1_lat_empty", 96'(le), 96'(34));
        check("t1_lat_free", 96'(lf), 96'(34));
        check("t1_exp_t", 96'(expq[0].t), 96'(5120));
        pop_check("t1");

        // Test 2: parallel ray, DIV skipped
        run_pair(nz, mk(0, 0, 5120), mk(0, 0, 0), mk(1024, 0, 0), 0, 0, le, lf, f1);
        check("t2_lat_empty", 96'(le), 96'(3));
        check("t2_lat_free", 96'(lf), 96'(3));
        pop_check("t2");

        // Test 3: negative t, origin/dir passthrough
        run_pair(nz, mk(0, 0, -2048), mk(0, 0, 0), mk(0, 0, 1024), 0, 0, le, lf, f1);
        check("t3_exp_t", 96'(expq[0].t), 96'(32'hFFFF_F800));
        pop_check("t3");
        run_pair(nz, mk(7, -9, -2048), mk(-3, 5, 0), mk(11, -13, 1024), 0, 0, le, lf, f1);
        pop_check("t3b");

        // Test 4: saturation and truncation
        run_pair(nz, mk(0, 0, 32'h7FFF0000), mk(0, 0, 0), mk(0, 0, 1), 0, 0, le, lf, f1);
        check("t4_exp_sat", 96'(expq[0].t), 96'(32'h7FFF_FFFF));
        pop_check("t4_sat");
        run_pair(nz, mk(0, 0, 1024), mk(0, 0, 0), mk(0, 0, 3072), 0, 0, le, lf, f1);
        check("t4_exp_third", 96'(expq[0].t), 96'(341));
        pop_check("t4_third");

        // Random pairs, popped as they complete
        for (int r = 0; r < 14; r++) begin
            n = mk(r16(), r16(), r16());
            v = mk(r16(), r16(), r16());
            o = mk(r16(), r16(), r16());
            d = ($urandom_range(0, 5) == 0) ? mk(0, 0, 0) : mk(r16(), r16(), r16());
            e = model(n, v, o, d);
            run_pair(n, v, o, d, 0, 0, le, lf, f1);
            check("rnd_lat", 96'(lf), 96'(e.den0 ? 3 : 34));
            pop_check("rnd");
        end

        // Test 5: fill the FIFO, 5th push ignored, then drain in order
        for (int r = 0; r < 4; r++) begin
            run_pair(mk(r16(), r16(), r16()), mk(r16(), r16(), r16()),
                     mk(r16(), r16(), r16()), mk(r16(), r16(), 1000 + r), 0, 0, le, lf, f1);
            check("t5_free", 96'(lf), 96'((r < 3) ? 34 : -1));
        end
        bus.tri_normal = nz;
        bus.v0 = mk(0, 0, 5120);
        bus.origin = '0;
        bus.dir = mk(0, 0, 1024);
        bus.in_wr_en = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        bus.in_wr_en = 1'b0;
        check("t5_full_held", 96'(bus.in_full), 96'(1));
        pop_check("t5_pop0");
        check("t5_full_drop", 96'(bus.in_full), 96'(0));
        pop_check("t5_pop1");
        pop_check("t5_pop2");
        pop_check("t5_pop3");
        check("t5_drained", 96'(bus.out_empty), 96'(1));

        // Simultaneous pop and PUSH keeps the count at one
        run_pair(nz, mk(0, 0, 3072), mk(0, 0, 0), mk(0, 0, 1024), 0, 0, le, lf, f1);
        run_pair(nz, mk(0, 0, 4096), mk(1, 2, 0), mk(0, 0, 1024), 33, 0, le, lf, f1);
        check("simul_free", 96'(lf), 96'(34));
        pop_check("simul_new");
        check("simul_empty", 96'(bus.out_empty), 96'(1));

        // Test 6: reset mid-DIV with two entries queued
        run_pair(nz, mk(0, 0, 1024), mk(0, 0, 0), mk(0, 0, 1024), 0, 0, le, lf, f1);
        run_pair(nz, mk(0, 0, 2048), mk(0, 0, 0), mk(0, 0, 1024), 0, 0, le, lf, f1);
        run_pair(nz, mk(0, 0, 3072), mk(0, 0, 0), mk(0, 0, 1024), 0, 10, le, lf, f1);
        expq.delete();
        check("t6_empty", 96'(bus.out_empty), 96'(1));
        check("t6_full",  96'(bus.in_full),   96'(0));
        check("t6_t",     96'(bus.out_t),     96'(0));
        run_pair(nz, mk(0, 0, 6144), mk(0, 0, 0), mk(0, 0, 1024), 0, 0, le, lf, f1);
        check("t6_lat", 96'(le), 96'(34));
        pop_check("t6_new");
        check("t6_final_empty", 96'(bus.out_empty), 96'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
